// File: rtl/axis2buffer_pkg.sv
// Shared definitions for the AXIS-to-row ingress converter: FSM encoding, counter widths
// and the error-weight helper.
package axis2buffer_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam int ERR_CNT_W  = 16;
    localparam int ROW_CNT_W  = 32;
    localparam int BEAT_CNT_W = 8;

    // Number of error events raised by one beat (0, 1 or 2).
    function automatic logic [1:0] err_weight(input logic colour_err, input logic frame_err);
        return {1'b0, colour_err} + {1'b0, frame_err};
    endfunction

endpackage

// File: rtl/axis2buffer_if.sv
// Pixel stream in, packed row out: the two handshakes of the ingress converter.
interface axis2buffer_if #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 8
);
    logic [DWIDTH-1:0] S_AXIS_TDATA;
    logic              S_AXIS_TVALID;
    logic              S_AXIS_TREADY;
    logic              S_AXIS_TLAST;
    logic [3:0]        S_AXIS_TKEEP;
    logic [3:0]        S_AXIS_TSTRB;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TSTRB, out_ready,
        output S_AXIS_TREADY, out_data, out_valid
    );

    modport master (
        output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TSTRB, out_ready,
        input  S_AXIS_TREADY, out_data, out_valid
    );
endinterface

// File: rtl/axis2buffer_sat_counter.sv
// Up-counter that adds 0, 1 or 2 per cycle and sticks at its all-ones maximum.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);
    logic [W:0]   sum_s;
    logic [W-1:0] count_r;

    // Widened sum so an overflow is visible in the top bit.
    always_comb begin
        sum_s = {1'b0, count_r} + {{(W-1){1'b0}}, inc};
    end

    // Count register, clamped at its maximum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= {W{1'b0}};
        end else if (sum_s[W]) begin
            count_r <= {W{1'b1}};
        end else begin
            count_r <= sum_s[W-1:0];
        end
    end

    assign count = count_r;
endmodule

// File: rtl/axis2buffer.sv
// AXI4-Stream slave that classifies each pixel colour as alive/dead and packs WIDTH beats
// (LSB first) into one row for the Game-of-Life core.
module axis2buffer
    import axis2buffer_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DWIDTH-1:0]     alive_color,
    input  logic [DWIDTH-1:0]     dead_color,
    axis2buffer_if.slave          bus,
    output logic [ROW_CNT_W-1:0]  num_rows,
    output logic [ERR_CNT_W-1:0]  num_errors,
    output logic [BEAT_CNT_W-1:0] counter
);
    state_t                state_r, state_next_s;
    logic [BEAT_CNT_W-1:0] counter_r, counter_next_s;
    logic [WIDTH-1:0]      row_r, row_next_s;
    logic [ROW_CNT_W-1:0]  rows_r;
    logic                  ready_r;
    logic                  beat_s, handoff_s, alive_s, colour_err_s, frame_err_s, last_cell_s;
    logic [1:0]            err_inc_s;
    logic                  unused_side_s;

    // Beat decode: handshakes, colour classification and framing checks.
    always_comb begin
        beat_s       = bus.S_AXIS_TVALID & ready_r;
        handoff_s    = (state_r == ST_EMIT) & bus.out_ready;
        alive_s      = (bus.S_AXIS_TDATA == alive_color);
        colour_err_s = !alive_s && (bus.S_AXIS_TDATA != dead_color);
        last_cell_s  = (counter_r == BEAT_CNT_W'(WIDTH - 1));
        frame_err_s  = last_cell_s ? !bus.S_AXIS_TLAST : bus.S_AXIS_TLAST;
        err_inc_s    = beat_s ? err_weight(colour_err_s, frame_err_s) : 2'd0;
    end

    // Next state, beat index and row contents.
    always_comb begin
        state_next_s   = state_r;
        counter_next_s = counter_r;
        row_next_s     = row_r;
        case (state_r)
            ST_FILL: begin
                if (beat_s) begin
                    // A short row clears every cell above the last received pixel.
                    for (int i = 0; i < WIDTH; i++) begin
                        if (i == int'(counter_r)) begin
                            row_next_s[i] = alive_s;
                        end else if (bus.S_AXIS_TLAST && (i > int'(counter_r))) begin
                            row_next_s[i] = 1'b0;
                        end else begin
                            row_next_s[i] = row_r[i];
                        end
                    end
                    if (last_cell_s || bus.S_AXIS_TLAST) begin
                        state_next_s   = ST_EMIT;
                        counter_next_s = {BEAT_CNT_W{1'b0}};
                    end else begin
                        counter_next_s = counter_r + BEAT_CNT_W'(1);
                    end
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_EMIT: begin
                if (handoff_s) begin
                    state_next_s = ST_FILL;
                    row_next_s   = {WIDTH{1'b0}};
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            default: begin
                state_next_s   = ST_FILL;
                counter_next_s = {BEAT_CNT_W{1'b0}};
                row_next_s     = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, row and handoff-count registers; ready is held low throughout reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_FILL;
            counter_r <= {BEAT_CNT_W{1'b0}};
            row_r     <= {WIDTH{1'b0}};
            rows_r    <= {ROW_CNT_W{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            counter_r <= counter_next_s;
            row_r     <= row_next_s;
            ready_r   <= (state_next_s == ST_FILL);
            if (handoff_s) begin
                rows_r <= rows_r + ROW_CNT_W'(1);
            end else begin
                rows_r <= rows_r;
            end
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (err_inc_s),
        .count (num_errors)
    );

    // Byte qualifiers carry no meaning for single-colour beats.
    assign unused_side_s     = ^{bus.S_AXIS_TKEEP, bus.S_AXIS_TSTRB};

    assign bus.S_AXIS_TREADY = ready_r;
    assign bus.out_valid     = (state_r == ST_EMIT);
    assign bus.out_data      = row_r;
    assign num_rows          = rows_r;
    assign counter           = counter_r;
endmodule

// File: tb/tb_axis2buffer.sv
// Directed bench for axis2buffer: a queue-based packet model checked every cycle, plus
// literal expectations for each scenario.
module tb_axis2buffer;
    localparam int          DW    = 32;
    localparam int          W     = 8;
    localparam logic [31:0] ALIVE = 32'hFFFF_FFFF;
    localparam logic [31:0] DEAD  = 32'h0000_0000;
    localparam logic [31:0] UNK   = 32'h1234_5678;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] num_rows;
    logic [15:0] num_errors;
    logic [7:0]  counter;
    int          n_checks = 0;
    int          n_fail   = 0;

    axis2buffer_if #(.DWIDTH(DW), .WIDTH(W)) bus ();

    axis2buffer #(.DWIDTH(DW), .WIDTH(W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .alive_color (ALIVE),
        .dead_color  (DEAD),
        .bus         (bus),
        .num_rows    (num_rows),
        .num_errors  (num_errors),
        .counter     (counter)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Packet model: pixels accumulate in a queue; a row forms on TLAST or on the WIDTH-th pixel.
    bit          m_pix[$];
    logic        m_ready = 1'b0;
    logic        m_emit  = 1'b0;
    logic [7:0]  m_row   = 8'h00;
    int unsigned m_rows  = 0;
    int          m_errs  = 0;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_pix.delete();
            m_ready = 1'b0;
            m_emit  = 1'b0;
            m_row   = 8'h00;
            m_rows  = 0;
            m_errs  = 0;
        end else begin
            if (m_emit) begin
                if (bus.out_ready) begin
                    m_emit = 1'b0;
                    m_rows++;
                end
            end else if (m_ready && bus.S_AXIS_TVALID) begin
                m_pix.push_back(bus.S_AXIS_TDATA == ALIVE);
                if (bus.S_AXIS_TDATA != ALIVE && bus.S_AXIS_TDATA != DEAD) m_errs++;
                if (bus.S_AXIS_TLAST || m_pix.size() == W) begin
                    if (!(bus.S_AXIS_TLAST && m_pix.size() == W)) m_errs++;
                    m_row = 8'h00;
                    foreach (m_pix[i]) m_row[i] = m_pix[i];
                    m_emit = 1'b1;
                    m_pix.delete();
                end
            end
            if (m_errs > 65535) m_errs = 65535;
            m_ready = !m_emit;
        end
    end

    // Every falling edge: DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        check("tready", 64'(bus.S_AXIS_TREADY), 64'(m_ready));
        check("out_valid", 64'(bus.out_valid), 64'(m_emit));
        if (m_emit) check("out_data", 64'(bus.out_data), 64'(m_row));
        check("num_rows", 64'(num_rows), 64'(m_rows));
        check("num_errors", 64'(num_errors), 64'(m_errs));
        check("counter", 64'(counter), m_emit ? 64'd0 : 64'(m_pix.size()));
    end

    task automatic send(input logic [31:0] d, input logic last);
        int to;
        bus.S_AXIS_TDATA  = d;
        bus.S_AXIS_TLAST  = last;
        bus.S_AXIS_TVALID = 1'b1;
        to = 0;
        while (!bus.S_AXIS_TREADY && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout at %0t: tready stayed 0, expected 1", $time);
        end else begin
            @(negedge clk);
        end
        bus.S_AXIS_TVALID = 1'b0;
        bus.S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] pat, input bit last, input int gap);
        for (int i = 0; i < W; i++) begin
            send(pat[i] ? ALIVE : DEAD, last && (i == W - 1));
            if (gap > 0 && i < W - 1) repeat ($urandom_range(gap, 0)) @(negedge clk);
        end
    endtask

    initial begin
        bus.S_AXIS_TDATA  = 32'h0;
        bus.S_AXIS_TVALID = 1'b0;
        bus.S_AXIS_TLAST  = 1'b0;
        bus.S_AXIS_TKEEP  = 4'hF;
        bus.S_AXIS_TSTRB  = 4'hF;
        bus.out_ready     = 1'b1;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tready", 64'(bus.S_AXIS_TREADY), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_rows", 64'(num_rows), 64'd0);
        check("rst_errors", 64'(num_errors), 64'd0);
        check("rst_counter", 64'(counter), 64'd0);
        #2 rstn = 1'b1;

        // Nominal packet A,D,A,A,D,D,D,A
        send_bits(8'h8D, 1'b1, 0);
        check("p1_data", 64'(bus.out_data), 64'h8D);
        @(negedge clk);
        check("p1_rows", 64'(num_rows), 64'd1);
        check("p1_errors", 64'(num_errors), 64'd0);

        // Back-pressure: row held while out_ready is low
        bus.out_ready = 1'b0;
        send_bits(8'h8D, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_tready", 64'(bus.S_AXIS_TREADY), 64'd0);
            check("bp_data", 64'(bus.out_data), 64'h8D);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_rows", 64'(num_rows), 64'd2);

        // Short row: TLAST on beat 3
        for (int i = 0; i < 4; i++) send(ALIVE, i == 3);
        check("short_data", 64'(bus.out_data), 64'h0F);
        @(negedge clk);
        check("short_errors", 64'(num_errors), 64'd1);
        send_bits(8'h8D, 1'b1, 0);
        check("after_short_data", 64'(bus.out_data), 64'h8D);
        @(negedge clk);

        // Missing TLAST; next beat starts a new row
        send_bits(8'h8D, 1'b0, 0);
        check("nolast_data", 64'(bus.out_data), 64'h8D);
        @(negedge clk);
        check("nolast_errors", 64'(num_errors), 64'd2);
        send_bits(8'h81, 1'b1, 0);
        check("next_row_data", 64'(bus.out_data), 64'h81);
        @(negedge clk);

        // Unknown colour on beat 2
        send(ALIVE, 1'b0); send(DEAD, 1'b0); send(UNK, 1'b0); send(ALIVE, 1'b0);
        send(DEAD, 1'b0);  send(DEAD, 1'b0); send(DEAD, 1'b0); send(ALIVE, 1'b1);
        check("unk_data", 64'(bus.out_data), 64'h89);
        @(negedge clk);
        check("unk_errors", 64'(num_errors), 64'd3);

        // Unknown colour and short TLAST on the same beat count twice
        send(ALIVE, 1'b0); send(UNK, 1'b1);
        check("dbl_data", 64'(bus.out_data), 64'h01);
        @(negedge clk);
        check("dbl_errors", 64'(num_errors), 64'd5);

        // Random TVALID gaps
        for (int p = 0; p < 3; p++) begin
            send_bits(8'h8D, 1'b1, 3);
            check("gap_data", 64'(bus.out_data), 64'h8D);
            @(negedge clk);
        end
        check("gap_rows", 64'(num_rows), 64'd11);

        // Reset mid-packet
        for (int i = 0; i < 4; i++) send(ALIVE, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check("midrst_tready", 64'(bus.S_AXIS_TREADY), 64'd0);
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_counter", 64'(counter), 64'd0);
        check("midrst_rows", 64'(num_rows), 64'd0);
        check("midrst_errors", 64'(num_errors), 64'd0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        send_bits(8'h8D, 1'b1, 0);
        check("post_rst_data", 64'(bus.out_data), 64'h8D);
        @(negedge clk);
        check("post_rst_rows", 64'(num_rows), 64'd1);
        check("post_rst_errors", 64'(num_errors), 64'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: bench did not complete, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
